// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: store push, load hazard probe, memory write drain.
// No logic, wiring only; the master drives stores, loads and bus_ack.
// The slave (the buffer) returns st_ready, ld_hazard, the bus request and occupancy.
// Ports: st_* push, ld_* hazard probe, bus_* drain, empty/count occupancy.
interface store_buffer_if #(
  parameter int PTR_W = 2
);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [3:0]       st_we;
  logic [31:0]      st_wdata;
  logic             st_ready;
  logic             ld_check;
  logic [31:0]      ld_addr;
  logic             ld_hazard;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [3:0]       bus_wstrb;
  logic [31:0]      bus_wdata;
  logic             bus_ack;
  logic             empty;
  logic [PTR_W:0]   count;

  modport slave (
    input  st_valid, st_addr, st_we, st_wdata, ld_check, ld_addr, bus_ack,
    output st_ready, ld_hazard, bus_req, bus_addr, bus_wstrb, bus_wdata, empty, count
  );

  modport master (
    output st_valid, st_addr, st_we, st_wdata, ld_check, ld_addr, bus_ack,
    input  st_ready, ld_hazard, bus_req, bus_addr, bus_wstrb, bus_wdata, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order write buffer between the store aligner and the data SRAM / memory bus port.
// Latency: a pushed store reaches the bus head the next cycle; one push and one pop per cycle.
// Backpressure: st_ready drops only when full (registered state only); the head is held until bus_ack.
// Ports: clk, resetn (async active-low), sb (slave modport: st_*, ld_*, bus_*, empty, count).
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          resetn,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [29:0]      addr_q  [DEPTH];
  logic [29:0]      addr_d  [DEPTH];
  logic [3:0]       we_q    [DEPTH];
  logic [3:0]       we_d    [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];

  logic empty, st_ready, push, pop, hit;
  logic unused_addr_lsbs;

  // Byte offsets within a word play no part in buffering or hazard matching.
  assign unused_addr_lsbs = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != FULL_CNT);
  // A zero-strobe store is handshaken but never occupies an entry.
  assign push     = sb.st_valid & st_ready & (sb.st_we != 4'b0000);
  assign pop      = !empty & sb.bus_ack;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    // Pop first: when full, a push cannot happen anyway, and otherwise the
    // slots differ, so ordering the two updates is only for readability.
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q]   = 1'b1;
      addr_d[wr_ptr_q]  = sb.st_addr[31:2];
      we_d[wr_ptr_q]    = sb.st_we;
      wdata_d[wr_ptr_q] = sb.st_wdata;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        we_q[i]    <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  // Hazard looks only at registered entries: a same-cycle push is ordered by
  // the pipeline, while a same-cycle pop still blocks the load this cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == sb.ld_addr[31:2])) hit = 1'b1;
    end
  end

  assign sb.ld_hazard = sb.ld_check & hit;
  assign sb.st_ready  = st_ready;
  assign sb.empty     = empty;
  assign sb.count     = count_q;
  assign sb.bus_req   = !empty;
  // Bus fields read as zero when idle so nothing stale is visible after reset or drain.
  assign sb.bus_addr  = empty ? 32'h0 : {addr_q[rd_ptr_q], 2'b00};
  assign sb.bus_wstrb = empty ? 4'h0  : we_q[rd_ptr_q];
  assign sb.bus_wdata = empty ? 32'h0 : wdata_q[rd_ptr_q];

endmodule
